mem_data_deskew: RTL and testbench
==================================

# mem_data_deskew

Output-side realignment for the systolic array. Rows leave the array skewed: lane n of a row arrives n cycles after lane 0. This block delays each lane so that all ARRAY lanes of a row are presented in the same cycle, ready for the output buffer write port. It also tracks stream framing (last row, row count, drain completion) for the buffer controller.

## Interface
- DATA_WIDTH, 8, bits per lane
- ARRAY, 16, lane count (systolic array width); legal range ≥ 2
- MEM_DATA_WIDTH, DATA_WIDTH*ARRAY, packed row width
- ROW_CNT_WIDTH, 16, width of the row counter
- clk  input  1  single clock, all logic rising-edge
- reset_n  input  1  asynchronous, active-low reset
- data_in  input  MEM_DATA_WIDTH  skewed lanes; lane n at bits [n*DATA_WIDTH +: DATA_WIDTH]
- in_valid  input  1  qualifies lane 0 of a row this cycle; lane n of the same row is valid n cycles later
- in_last  input  1  qualifies with in_valid; marks final row of the stream
- data_out  output  MEM_DATA_WIDTH  aligned row
- out_valid  output  1  data_out holds a complete aligned row
- out_last  output  1  aligned row is the stream's final row
- row_count  output  ROW_CNT_WIDTH  rows emitted since stream start
- busy  output  1  FSM not in IDLE
- done  output  1  one-cycle pulse after the final row is emitted
- protocol_err  output  1  sticky protocol-violation flag

## Operation
- Lane n delay line: ARRAY-n registers (lane 0: ARRAY, lane ARRAY-1: 1). The final stage of every lane is the output register.
- in_valid/in_last pass through an ARRAY-deep shift register, producing out_valid/out_last.
- No backpressure. The consumer must accept every out_valid row.
- FSM states:
  - IDLE: on in_valid, go to STREAM; row_count clears to 0 on that transition.
  - STREAM: on in_valid && in_last, go to DRAIN.
  - DRAIN: wait for out_valid && out_last. In that cycle, return to IDLE next cycle, with done high during that next cycle.
  - A stream of one row (in_valid && in_last in IDLE) goes IDLE→DRAIN directly; row_count still clears.
- row_count increments on each out_valid cycle and wraps to 0 after all-ones.
- protocol_err sets on in_valid during DRAIN and holds until reset. The row still enters the datapath and is emitted normally. FSM state is not changed.
- in_last without in_valid is ignored.
- Reset values: data_out 0, out_valid 0, out_last 0, row_count 0, busy 0, done 0, protocol_err 0, FSM IDLE. All delay-line registers clear to 0.
- Reset mid-stream discards all in-flight rows; no partial row is emitted afterward.

## Timing
- Row whose lane 0 arrives at cycle T: all lanes appear on data_out, with out_valid, at cycle T+ARRAY.
- Fixed latency ARRAY cycles, full throughput: one row per cycle, back-to-back in_valid allowed.
- done is asserted at cycle T_last+ARRAY+1; busy falls in that same cycle.
- data_in lanes are sampled every cycle regardless of in_valid; only rows framed by in_valid are reported valid.

## Configuration
- DESKEW_ZERO_FILL_EN defined: data_out is forced to all-zero in any cycle where out_valid is 0, using a gated output register.
- Undefined: data_out shows raw delay-line contents whenever out_valid is 0. This saves ARRAY*DATA_WIDTH AND gates.
- Valid-cycle behaviour is identical either way.

## Structure
- Shared package (`mem_sync_pkg`):
  - FSM state enum (IDLE, STREAM, DRAIN)
  - default ARRAY/DATA_WIDTH constants, shared with the input-side skew block
- One sub-module, `deskew_lane`: parameters DATA_WIDTH and DEPTH, async active-low reset, plain shift register.
  - The top generates ARRAY instances with DEPTH = ARRAY-n.
  - Valid/last framing and the FSM live in the top.

## Test plan
Use ARRAY=4, DATA_WIDTH=8.
- Single row, in_valid+in_last at T=0 with lane n carrying 8'h10+n at T=n:
  - data_out=32'h13121110 with out_valid, out_last at T=4
  - done at T=5; row_count=1
- Eight back-to-back rows (row r lane n = 8'h(r*16+n)), last on row 7:
  - out_valid high for exactly cycles 4..11, each row aligned
  - done at 12; row_count=8
- in_valid at cycle 1 of DRAIN:
  - protocol_err=1 and stays 1 through later streams
  - the extra row is still emitted aligned
- reset_n pulsed low at T=2 during a 3-row stream:
  - all outputs 0 immediately (asynchronous)
  - no out_valid afterwards; FSM IDLE
- Idle cycles with random data_in: out_valid=0 throughout.
  - With DESKEW_ZERO_FILL_EN, data_out=0 throughout; without it, no check on data_out.
- ROW_CNT_WIDTH=4, 17-row stream: row_count wraps 15→0 and ends at 1.

Source files
------------

// File: rtl/mem_sync_pkg.sv
// rtl/mem_sync_pkg.sv - shared types and default sizes for the array skew/deskew blocks
package mem_sync_pkg;

   // Framing FSM states used by the deskew block
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   // Default array geometry, shared with the input-side skew block
   localparam int DEFAULT_ARRAY      = 16;
   localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/deskew_lane.sv
// rtl/deskew_lane.sv - fixed-depth per-lane delay line; last stage is the lane's output register
module deskew_lane #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] r_stage [DEPTH];

   // Shift the lane sample one stage per cycle; data is taken every cycle regardless of framing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign dout = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_data_deskew.sv
// rtl/mem_data_deskew.sv - realigns skewed systolic-array rows and tracks stream framing; optional DESKEW_ZERO_FILL_EN zeroes data_out outside valid rows
module mem_data_deskew
   import mem_sync_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int ARRAY          = DEFAULT_ARRAY,
   parameter int MEM_DATA_WIDTH = DATA_WIDTH * ARRAY,
   parameter int ROW_CNT_WIDTH  = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [MEM_DATA_WIDTH-1:0] data_in,
   input  logic                      in_valid,
   input  logic                      in_last,
   output logic [MEM_DATA_WIDTH-1:0] data_out,
   output logic                      out_valid,
   output logic                      out_last,
   output logic [ROW_CNT_WIDTH-1:0]  row_count,
   output logic                      busy,
   output logic                      done,
   output logic                      protocol_err
);

   logic [MEM_DATA_WIDTH-1:0] w_raw;
   logic [ARRAY-1:0]          r_valid_sr;
   logic [ARRAY-1:0]          r_last_sr;
   state_t                    r_state;
   logic [ROW_CNT_WIDTH-1:0]  r_row_count;
   logic                      r_done;
   logic                      r_perr;

   // Lane n arrives n cycles late, so it needs ARRAY-n stages to line up with lane 0
   for (genvar n = 0; n < ARRAY; n++) begin : g_lane
      deskew_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (ARRAY - n)
      ) u_lane (
         .clk     (clk),
         .reset_n (reset_n),
         .din     (data_in[n*DATA_WIDTH +: DATA_WIDTH]),
         .dout    (w_raw[n*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // Framing travels alongside lane 0, so it sees the full ARRAY-cycle latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid_sr <= '0;
         r_last_sr  <= '0;
      end else begin
         r_valid_sr <= {r_valid_sr[ARRAY-2:0], in_valid};
         r_last_sr  <= {r_last_sr[ARRAY-2:0], in_valid & in_last};
      end
   end

   assign out_valid = r_valid_sr[ARRAY-1];
   assign out_last  = r_last_sr[ARRAY-1];

`ifdef DESKEW_ZERO_FILL_EN
   assign data_out = out_valid ? w_raw : '0;
`else
   assign data_out = w_raw;
`endif

   // Stream framing FSM with row counter, done pulse and sticky protocol error
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_row_count <= '0;
         r_done      <= 1'b0;
         r_perr      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // A new stream restarts the count even if a stray row is emitted in the same cycle
         if (r_state == IDLE && in_valid) begin
            r_row_count <= '0;
         end else if (out_valid) begin
            r_row_count <= r_row_count + ROW_CNT_WIDTH'(1);
         end
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_state <= in_last ? DRAIN : STREAM;
               end
            end
            STREAM: begin
               if (in_valid && in_last) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               // Rows arriving while draining still flow through; only the flag records it
               if (in_valid) begin
                  r_perr <= 1'b1;
               end
               if (out_valid && out_last) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign row_count    = r_row_count;
   assign busy         = (r_state != IDLE);
   assign done         = r_done;
   assign protocol_err = r_perr;

endmodule

// File: tb/tb_mem_data_deskew.sv
// tb/tb_mem_data_deskew.sv - self-checking bench for mem_data_deskew with ARRAY=4, DATA_WIDTH=8
module tb_mem_data_deskew;

   localparam int DW = 8;
   localparam int AR = 4;
   localparam int MW = DW * AR;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [MW-1:0] data_in = '0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;

   logic [MW-1:0] data_out, data_out_w;
   logic          out_valid, out_valid_w;
   logic          out_last, out_last_w;
   logic [15:0]   row_count;
   logic [3:0]    row_count_w;
   logic          busy, busy_w;
   logic          done, done_w;
   logic          protocol_err, protocol_err_w;

   mem_data_deskew #(.DATA_WIDTH(DW), .ARRAY(AR), .ROW_CNT_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_valid(in_valid), .in_last(in_last),
      .data_out(data_out), .out_valid(out_valid), .out_last(out_last), .row_count(row_count),
      .busy(busy), .done(done), .protocol_err(protocol_err)
   );

   mem_data_deskew #(.DATA_WIDTH(DW), .ARRAY(AR), .ROW_CNT_WIDTH(4)) dut_w (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .in_valid(in_valid), .in_last(in_last),
      .data_out(data_out_w), .out_valid(out_valid_w), .out_last(out_last_w), .row_count(row_count_w),
      .busy(busy_w), .done(done_w), .protocol_err(protocol_err_w)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: per-edge input history plus stream bookkeeping
   int            e;
   logic          hv [512];
   logic          hl [512];
   logic [MW-1:0] hd [512];
   logic          m_busy, m_perr, m_done;
   int            m_drain_end;
   int            m_rows;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic gv(input int i);
      return (i >= 0) ? hv[i] : 1'b0;
   endfunction

   function automatic logic gl(input int i);
      return (i >= 0) ? hl[i] : 1'b0;
   endfunction

   function automatic logic [MW-1:0] gd(input int i);
      return (i >= 0) ? hd[i] : '0;
   endfunction

   task automatic model_reset();
      e = 0;
      for (int i = 0; i < 512; i++) begin
         hv[i] = 1'b0;
         hl[i] = 1'b0;
         hd[i] = '0;
      end
      m_busy = 1'b0;
      m_perr = 1'b0;
      m_done = 1'b0;
      m_drain_end = -1;
      m_rows = 0;
   endtask

   task automatic step(input logic v, input logic l, input logic [MW-1:0] d);
      logic          was_drain;
      logic          ev, el;
      logic [MW-1:0] ed, tmp;
      @(negedge clk);
      in_valid = v;
      in_last  = l;
      data_in  = d;
      @(posedge clk);
      was_drain = (m_drain_end >= 0);
      if (!m_busy && v) m_rows = 0;
      else if (gv(e - AR)) m_rows = m_rows + 1;
      if (was_drain && v) m_perr = 1'b1;
      if (!was_drain && v && l) m_drain_end = e + AR;
      if (!m_busy && v) m_busy = 1'b1;
      if (was_drain && e == m_drain_end) begin
         m_done = 1'b1;
         m_busy = 1'b0;
         m_drain_end = -1;
      end else begin
         m_done = 1'b0;
      end
      hv[e] = v;
      hl[e] = v & l;
      hd[e] = d;
      ev = gv(e - AR + 1);
      el = gl(e - AR + 1);
      ed = '0;
      for (int n = 0; n < AR; n++) begin
         tmp = gd(e - AR + 1 + n);
         ed[n*DW +: DW] = tmp[n*DW +: DW];
      end
      e++;
      #1;
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("out_last", 32'(out_last), 32'(el));
      chk("out_valid_w", 32'(out_valid_w), 32'(ev));
      chk("out_last_w", 32'(out_last_w), 32'(el));
      if (ev) begin
         chk("data_out", data_out, ed);
         chk("data_out_w", data_out_w, ed);
      end
`ifdef DESKEW_ZERO_FILL_EN
      else begin
         chk("data_out_zero", data_out, 32'h0);
         chk("data_out_w_zero", data_out_w, 32'h0);
      end
`endif
      chk("busy", 32'(busy), 32'(m_busy));
      chk("busy_w", 32'(busy_w), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("done_w", 32'(done_w), 32'(m_done));
      chk("row_count", 32'(row_count), 32'(m_rows & 16'hffff));
      chk("row_count_w", 32'(row_count_w), 32'(m_rows & 4'hf));
      chk("protocol_err", 32'(protocol_err), 32'(m_perr));
      chk("protocol_err_w", 32'(protocol_err_w), 32'(m_perr));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_data_out"}, data_out, 32'h0);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_out_last"}, 32'(out_last), 32'h0);
      chk({tag, "_row_count"}, 32'(row_count), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
      chk({tag, "_done"}, 32'(done), 32'h0);
      chk({tag, "_protocol_err"}, 32'(protocol_err), 32'h0);
   endtask

   initial begin
      logic [MW-1:0] d;

      // Reset state
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Single row, lane n carries 8'h10+n at T=n
      for (int k = 0; k < 5; k++) begin
         d = MW'($urandom);
         if (k < AR) d[k*DW +: DW] = 8'h10 + 8'(k);
         step(k == 0, k == 0, d);
         if (k == 3) begin
            chk("single_row_data", data_out, 32'h13121110);
            chk("single_row_last", 32'(out_last), 32'h1);
         end
         if (k == 4) begin
            chk("single_row_done", 32'(done), 32'h1);
            chk("single_row_count", 32'(row_count), 32'h1);
         end
      end
      repeat (2) step(1'b0, 1'b0, MW'($urandom));

      // Eight back-to-back rows, row r lane n = r*16+n
      model_reset();
      for (int k = 0; k < 13; k++) begin
         for (int n = 0; n < AR; n++) begin
            if (k - n >= 0 && k - n <= 7) d[n*DW +: DW] = 8'((k - n) * 16 + n);
            else d[n*DW +: DW] = 8'($urandom);
         end
         step(k < 8, k == 7, d);
         if (k == 11) begin
            chk("burst8_done", 32'(done), 32'h1);
            chk("burst8_count", 32'(row_count), 32'h8);
         end
      end

      // Protocol violation: extra row in the first DRAIN cycle
      step(1'b1, 1'b0, MW'($urandom));
      step(1'b1, 1'b1, MW'($urandom));
      step(1'b1, 1'b0, MW'($urandom));
      repeat (7) step(1'b0, 1'b0, MW'($urandom));
      chk("perr_set", 32'(protocol_err), 32'h1);

      // Idle cycles with random data, then a later stream keeps the error flag
      repeat (6) step(1'b0, 1'b0, MW'($urandom));
      for (int k = 0; k < 9; k++) step(k < 3, k == 2, MW'($urandom));
      chk("perr_sticky", 32'(protocol_err), 32'h1);

      // Asynchronous reset in the middle of a 3-row stream
      step(1'b1, 1'b0, MW'($urandom));
      step(1'b1, 1'b0, MW'($urandom));
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = 1'b1;
      data_in  = MW'($urandom);
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      reset_n  = 1'b1;
      model_reset();
      repeat (8) step(1'b0, 1'b0, MW'($urandom));
      chk("post_reset_busy", 32'(busy), 32'h0);

      // 17-row stream: the 4-bit counter wraps 15 -> 0 and ends at 1
      for (int k = 0; k < 22; k++) step(k < 17, k == 16, MW'($urandom));
      chk("wrap_count_w", 32'(row_count_w), 32'h1);
      chk("wrap_count", 32'(row_count), 32'd17);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
